// File: rtl/bp_pkg.sv
// Shared branch-predictor types and constants used by the update scheduler and the BHT.
package bp_pkg;

  localparam int BP_SET_NUM       = 8;
  localparam int BP_ASSOCIATIVITY = 2;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] dest;
    logic        taken;
  } bp_upd_t;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } bp_state_e;

  function automatic logic [1:0] bp_lane_cnt(input logic a, input logic b);
    return {1'b0, a} + {1'b0, b};
  endfunction

endpackage

// File: rtl/bp_upd_fifo.sv
// Two-write / one-read compacting update queue with a registered head.
// The head register is loaded and the entry popped in the same edge whenever pop_en is high.
module bp_upd_fifo
  import bp_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic    clk,
  input  logic    reset,
  input  logic    pop_en,
  input  logic    in0_valid,
  input  bp_upd_t in0_data,
  input  logic    in1_valid,
  input  bp_upd_t in1_data,
  output logic    out_valid,
  output bp_upd_t out_data,
  output logic    issue,
  output logic [1:0] drop_num
);

  localparam int PW = $clog2(DEPTH);

  bp_upd_t        mem_r [DEPTH];
  logic [PW-1:0]  wr_ptr_r;
  logic [PW-1:0]  rd_ptr_r;
  logic [PW:0]    count_r;

  logic           pop_ex_s;
  logic [PW:0]    space_s;
  logic [1:0]     n_valid_s;
  logic [1:0]     n_acc_s;
  bp_upd_t        first_s;
  bp_upd_t        head_s;
  logic           issue_s;

  // Admission: same-cycle pop of a stored entry frees one slot; extra lanes beyond space drop youngest-first.
  always_comb begin
    pop_ex_s  = pop_en && (count_r != '0);
    space_s   = (PW+1)'(DEPTH) - count_r + {{PW{1'b0}}, pop_ex_s};
    n_valid_s = bp_lane_cnt(in0_valid, in1_valid);
    first_s   = in0_valid ? in0_data : in1_data;
    if (space_s >= (PW+1)'(2)) begin
      n_acc_s = n_valid_s;
    end else if (space_s == (PW+1)'(1)) begin
      n_acc_s = (n_valid_s != 2'd0) ? 2'd1 : 2'd0;
    end else begin
      n_acc_s = 2'd0;
    end
    // An empty queue forwards the oldest arriving entry straight to the head register.
    head_s   = (count_r != '0) ? mem_r[rd_ptr_r] : first_s;
    issue_s  = pop_en && ((count_r != '0) || (n_acc_s != 2'd0));
    drop_num = n_valid_s - n_acc_s;
    issue    = issue_s;
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (n_acc_s != 2'd0) begin
      mem_r[wr_ptr_r] <= first_s;
    end
    if (n_acc_s == 2'd2) begin
      mem_r[wr_ptr_r + PW'(1)] <= in1_data;
    end
  end

  // Pointers, occupancy and the registered head.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r  <= '0;
      rd_ptr_r  <= '0;
      count_r   <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      wr_ptr_r  <= wr_ptr_r + PW'(n_acc_s);
      rd_ptr_r  <= rd_ptr_r + PW'(issue_s);
      count_r   <= count_r + (PW+1)'(n_acc_s) - (PW+1)'(issue_s);
      out_valid <= issue_s;
      out_data  <= issue_s ? head_s : '0;
    end
  end

endmodule

// File: rtl/bp_update_sched.sv
// BHT update scheduler: post-reset clear sweep, then drains queued branch updates one per cycle.
// Optional statistics counters are enabled by defining BP_UPD_STATS_EN.
module bp_update_sched
  import bp_pkg::*;
#(
  parameter int DEPTH         = 4,
  parameter int SET_NUM       = BP_SET_NUM,
  parameter int ASSOCIATIVITY = BP_ASSOCIATIVITY
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in0_valid,
  input  logic        in1_valid,
  input  logic [31:0] in0_pc,
  input  logic [31:0] in1_pc,
  input  logic [31:0] in0_dest,
  input  logic [31:0] in1_dest,
  input  logic        in0_taken,
  input  logic        in1_taken,
  output logic        upd_valid,
  output logic [31:0] upd_pc,
  output logic [31:0] upd_dest,
  output logic        upd_taken,
  output logic        upd_write,
  output logic        init_we,
  output logic [$clog2(SET_NUM)+$clog2(ASSOCIATIVITY)-1:0] init_addr,
  output logic        init_busy,
  output logic [15:0] drop_cnt,
  output logic [31:0] upd_cnt
);

  localparam int AW = $clog2(SET_NUM) + $clog2(ASSOCIATIVITY);

  bp_state_e     state_r;
  bp_state_e     state_s;
  logic [AW-1:0] addr_r;
  logic          init_we_s;
  logic          init_busy_s;

  bp_upd_t       in0_data_s;
  bp_upd_t       in1_data_s;
  bp_upd_t       head_s;
  logic          head_valid_s;
  logic          issue_s;
  logic [1:0]    drop_num_s;

  assign in0_data_s = '{pc: in0_pc, dest: in0_dest, taken: in0_taken};
  assign in1_data_s = '{pc: in1_pc, dest: in1_dest, taken: in1_taken};

  bp_upd_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .pop_en    (state_r == ST_RUN),
    .in0_valid (in0_valid),
    .in0_data  (in0_data_s),
    .in1_valid (in1_valid),
    .in1_data  (in1_data_s),
    .out_valid (head_valid_s),
    .out_data  (head_s),
    .issue     (issue_s),
    .drop_num  (drop_num_s)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_INIT;
    end else begin
      state_r <= state_s;
    end
  end

  // Next state and sweep strobes; the sweep ends after the all-ones address.
  always_comb begin
    state_s     = state_r;
    init_we_s   = 1'b0;
    init_busy_s = 1'b0;
    case (state_r)
      ST_INIT: begin
        init_we_s   = 1'b1;
        init_busy_s = 1'b1;
        if (addr_r == {AW{1'b1}}) begin
          state_s = ST_RUN;
        end else begin
          state_s = ST_INIT;
        end
      end
      ST_RUN: begin
        state_s = ST_RUN;
      end
      default: begin
        state_s = ST_INIT;
      end
    endcase
  end

  // Sweep address counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_r <= '0;
    end else if (state_r == ST_INIT) begin
      addr_r <= addr_r + AW'(1);
    end else begin
      addr_r <= addr_r;
    end
  end

  assign init_we   = init_we_s;
  assign init_busy = init_busy_s;
  assign init_addr = addr_r;
  assign upd_valid = head_valid_s;
  assign upd_write = head_valid_s;
  assign upd_pc    = head_s.pc;
  assign upd_dest  = head_s.dest;
  assign upd_taken = head_s.taken;

`ifdef BP_UPD_STATS_EN
  logic [15:0] drop_cnt_r;
  logic [31:0] upd_cnt_r;
  logic [16:0] drop_sum_s;

  assign drop_sum_s = {1'b0, drop_cnt_r} + 17'(drop_num_s);

  // Drop counter saturates; issue counter wraps.
  always_ff @(posedge clk) begin
    if (reset) begin
      drop_cnt_r <= 16'h0000;
      upd_cnt_r  <= 32'h0000_0000;
    end else begin
      drop_cnt_r <= drop_sum_s[16] ? 16'hFFFF : drop_sum_s[15:0];
      upd_cnt_r  <= upd_cnt_r + 32'(issue_s);
    end
  end

  assign drop_cnt = drop_cnt_r;
  assign upd_cnt  = upd_cnt_r;
`else
  logic unused_stats_s;
  assign unused_stats_s = ^{issue_s, drop_num_s};
  assign drop_cnt = 16'h0000;
  assign upd_cnt  = 32'h0000_0000;
`endif

endmodule

// File: doc/bp_update_sched.md
# bp_update_sched

Update scheduler for the branch history table: sits between the two execute lanes and the BHT's single update/replace port. Captures up to two resolved-branch updates per cycle, queues them in program order, and drains one per cycle into the BHT. After reset it sequences a clear sweep over every BHT entry before issuing any update.

## Interface
- `DEPTH`, 4: update queue entries; power of two, ≥2.
- `SET_NUM`, 8: BHT sets; must match the BHT instance.
- `ASSOCIATIVITY`, 2: BHT ways; must match the BHT instance.
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high reset.
- `in0_valid` / `in1_valid`  in  1  lane 0/1 carries a resolved branch this cycle; lane 0 is older.
- `in0_pc` / `in1_pc`  in  32  PC of the executed branch.
- `in0_dest` / `in1_dest`  in  32  resolved branch target.
- `in0_taken` / `in1_taken`  in  1  branch outcome.
- `upd_valid`  out  1  an update is presented to the BHT this cycle.
- `upd_pc`  out  32  drives BHT `executed_branch_pc`.
- `upd_dest`  out  32  drives BHT `dest_pc`.
- `upd_taken`  out  1  drives BHT `is_taken`.
- `upd_write`  out  1  drives BHT `is_write`; equals `upd_valid`.
- `init_we`  out  1  clear-sweep write strobe.
- `init_addr`  out  log2(SET_NUM)+log2(ASSOCIATIVITY)  sweep address, `{index, line}`.
- `init_busy`  out  1  sweep in progress.
- `drop_cnt`  out  16  updates discarded on full (only with `BP_UPD_STATS_EN`).
- `upd_cnt`  out  32  updates issued (only with `BP_UPD_STATS_EN`).

## Operation
- FSM states: INIT, RUN. `reset` forces INIT and clears `init_addr`, the queue, and the counters.
- INIT: `init_we`=1 and `init_busy`=1 every cycle; `init_addr` increments by 1 per cycle. At all-ones the FSM moves to RUN on the next edge. The sweep lasts exactly SET_NUM*ASSOCIATIVITY cycles.
- RUN: `init_we`=0, `init_busy`=0. The head entry, if any, is presented on `upd_*` and popped that cycle. The BHT always accepts, so there is no ready signal.
- In INIT, enqueue still operates, but nothing drains.
- Enqueue order: lane 0 before lane 1. Valid lanes are compacted, so a lone `in1_valid` occupies one slot.
- Space is computed as DEPTH − count + pop, where pop is same-cycle.
  - Room for both: accept both.
  - Room for one with both valid: accept lane 0, drop lane 1.
  - No room: drop all.
  - Drops never reorder accepted entries.
- Pointers are log2(DEPTH)-bit and wrap naturally. Count is log2(DEPTH)+1 bits. Empty when count=0; full when count=DEPTH.
- When `upd_valid`=0, `upd_pc`, `upd_dest` and `upd_taken` drive 0.

## Timing
- Reset values: `upd_valid`=0, `upd_write`=0, `upd_*`=0, `init_we`=1, `init_busy`=1, `init_addr`=0, counters 0.
- `upd_*` is registered (queue head register).
- Latency from input to `upd_valid` is 1 cycle when the queue is empty and the FSM is in RUN.
  - Two same-cycle inputs issue on consecutive cycles.
- First possible `upd_valid` is cycle SET_NUM*ASSOCIATIVITY+1 after reset deasserts. The queue may have filled during the sweep.
- Simultaneous push and pop at full: the pop frees a slot for the push in the same cycle.
- Reset mid-operation: queued updates are lost, and the sweep restarts at address 0 on the cycle after reset.

## Configuration
- `BP_UPD_STATS_EN` defined:
  - `upd_cnt` increments per issued update.
  - `drop_cnt` increments by the number of lanes dropped that cycle (0–2) and saturates at 0xFFFF.
  - `upd_cnt` wraps.
- Not defined: both ports are tied to 0 and no counter flops exist.

## Structure
- Shared package `bp_pkg` holds:
  - `bp_upd_t`, a packed struct {pc, dest, taken};
  - the `BP_SET_NUM` and `BP_ASSOCIATIVITY` constants, shared with the BHT;
  - the FSM state enum.
- One sub-module, `bp_upd_fifo`: a 2-write/1-read compacting FIFO of `bp_upd_t`. The top level holds the FSM, the sweep counter and the stats.

## Test plan
- Reset release, no inputs -> `init_we`=1 for 16 cycles with `init_addr` 0..15, then `init_busy`=0; `upd_valid` stays 0 throughout.
- RUN, empty queue; lane 0 pc=0x1000, dest=0x2000, taken=1 -> next cycle `upd_valid`=1 with those values, then `upd_valid`=0.
- Both lanes valid (pc 0x1000, 0x1004) -> issued on two consecutive cycles, 0x1000 first. Lone lane 1 -> occupies one slot, issued normally.
- During INIT, push 6 updates, DEPTH=4 -> 4 accepted and 2 dropped (`drop_cnt`=2); after the sweep, 4 updates issue in order.
- Queue holds 3 at RUN; both lanes valid -> pop and push both accepted, count becomes 4; next cycle both valid again -> lane 0 accepted, `drop_cnt`+1.
- Assert reset with the queue non-empty -> `upd_valid`=0 the next cycle, the sweep restarts at 0, and the old entries never appear.
